motor_control: RTL and testbench



---
 rtl/motor_control_if.sv | 13 +
 rtl/motor_control.sv | 78 +++++++
 tb/tb_motor_control.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/motor_control_if.sv
// Motor control bus: controller-side direction and frame count in, PWM pin out.
interface motor_control_if #(
  parameter int COUNT_W = 21
);
  logic               direction;
  logic [COUNT_W-1:0] count;
  logic               pwm;

  // Controller/timebase side drives the inputs and observes the pin.
  modport master (output direction, output count, input pwm);
  // PWM generator side.
  modport slave  (input direction, input count, output pwm);
endinterface

// File: rtl/motor_control.sv
// Servo-style PWM generator: one high pulse per frame whose width depends on
// the selected direction. The frame position comes from the shared timebase.
// Optional feature macro MOTOR_CONTROL_DIR_LATCH_EN: the direction is latched
// at each frame start so a pulse is never truncated or stretched mid-frame.
module motor_control #(
  parameter int COUNT_W    = 21,
  parameter int PULSE_DIR0 = 100000,
  parameter int PULSE_DIR1 = 200000,
  parameter int FRAME      = 2000000
) (
  input logic             clk,
  input logic             reset,
  motor_control_if.slave  bus
);

  localparam logic [COUNT_W-1:0] W0      = COUNT_W'(PULSE_DIR0);
  localparam logic [COUNT_W-1:0] W1      = COUNT_W'(PULSE_DIR1);
  localparam logic [COUNT_W-1:0] FRAME_C = COUNT_W'(FRAME);

  typedef enum logic [1:0] {
    MOTOR_OFF  = 2'd0,
    MOTOR_HIGH = 2'd1,
    MOTOR_LOW  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               sel_dir;
  logic [COUNT_W-1:0] width;
  logic               frame_start;
  logic               out_of_range;

  assign frame_start  = (bus.count == '0);
  assign out_of_range = (bus.count >= FRAME_C);

`ifdef MOTOR_CONTROL_DIR_LATCH_EN
  logic dir_q;

  // Capture direction only at frame start so the width is fixed for the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            dir_q <= 1'b0;
    else if (frame_start) dir_q <= bus.direction;
  end

  assign sel_dir = dir_q;
`else
  assign sel_dir = bus.direction;
`endif

  assign width = sel_dir ? W1 : W0;

  // State register; reset forces OFF without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MOTOR_OFF;
    else       state_q <= state_d;
  end

  // Next-state logic: one pulse per frame, LOW is left only on frame restart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MOTOR_OFF: begin
        if (bus.count < width && !out_of_range) state_d = MOTOR_HIGH;
        else                                    state_d = MOTOR_LOW;
      end
      MOTOR_HIGH: begin
        if (bus.count >= width || out_of_range) state_d = MOTOR_LOW;
      end
      MOTOR_LOW: begin
        if (frame_start) state_d = MOTOR_HIGH;
      end
      default: state_d = MOTOR_OFF;
    endcase
  end

  // Pin decoded straight from the state register, so it cannot glitch.
  assign bus.pwm = (state_q == MOTOR_HIGH);

endmodule

// File: tb/tb_motor_control.sv
// Self-checking bench for motor_control with a shrunk frame
// (W0=10, W1=20, FRAME=200). The bench plays the timebase role itself.
module tb_motor_control;

  localparam int CW = 8;
  localparam int P0 = 10;
  localparam int P1 = 20;
  localparam int FR = 200;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  motor_control_if #(.COUNT_W(CW)) bus ();

  motor_control #(
    .COUNT_W   (CW),
    .PULSE_DIR0(P0),
    .PULSE_DIR1(P1),
    .FRAME     (FR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment of consecutive cycles: count starts at cnt, advances by inc per
  // cycle, and pwm is expected to equal exp after every edge of the segment.
  typedef struct {
    logic rst;
    logic dir;
    int   cnt;
    int   len;
    logic inc;
    logic exp;
  } seg_t;

  seg_t tbl[$];
  logic exp_q[$];

  task automatic add(input logic rst, input logic dir, input int cnt,
                     input int len, input logic inc, input logic exp);
    seg_t s;
    s.rst = rst; s.dir = dir; s.cnt = cnt; s.len = len; s.inc = inc; s.exp = exp;
    tbl.push_back(s);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: pwm=%b expected=%b at t=%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, push the expectation, sample after the edge.
  task automatic cyc(input string name, input logic rst, input logic dir,
                     input int cnt, input logic exp);
    logic e;
    reset         = rst;
    bus.direction = dir;
    bus.count     = CW'(cnt);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s cnt=%0d", name, cnt), bus.pwm, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.direction = 1'b0;
    bus.count = '0;
    #3;
    check("reset_state", bus.pwm, 1'b0);

    // Reset held, then direction 0 frames with wrap.
    add(1, 0, 0,  3,   0, 0);
    add(0, 0, 0,  P0,  1, 1);
    add(0, 0, P0, FR-P0, 1, 0);
    add(0, 0, 0,  P0,  1, 1);
    add(0, 0, P0, FR-P0, 1, 0);
    // Direction 1 frame.
    add(0, 1, 0,  P1,  1, 1);
    add(0, 1, P1, FR-P1, 1, 0);
    // Direction 1->0 at count 15, mid-pulse.
    add(0, 1, 0,  15,  1, 1);
`ifdef MOTOR_CONTROL_DIR_LATCH_EN
    add(0, 0, 15, P1-15, 1, 1);
    add(0, 0, P1, FR-P1, 1, 0);
`else
    add(0, 0, 15, FR-15, 1, 0);
`endif
    add(0, 0, 0,  P0,  1, 1);
    add(0, 0, P0, FR-P0, 1, 0);
    // Direction 0->1 after the pulse ended: no restart inside the frame.
    add(0, 0, 0,  P0,  1, 1);
    add(0, 0, P0, 2,   1, 0);
    add(0, 1, P0+2, FR-P0-2, 1, 0);
    add(0, 1, 0,  P1,  1, 1);
    add(0, 1, P1, FR-P1, 1, 0);
    // Out-of-range count mid-pulse, then stays low until count==0.
    add(0, 0, 0,  5,   1, 1);
    add(0, 0, FR+1, 1, 0, 0);
    add(0, 0, 6,  3,   1, 0);
    add(0, 0, FR, 3,   1, 0);
    add(0, 0, 0,  P0,  1, 1);
    add(0, 0, P0, 5,   1, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].len; k++) begin
        cyc($sformatf("seg%0d", i), tbl[i].rst, tbl[i].dir,
            tbl[i].inc ? tbl[i].cnt + k : tbl[i].cnt, tbl[i].exp);
      end
    end

    // Reset mid-pulse: pwm must drop before any clock edge.
    for (int c = 0; c < 5; c++) cyc("pre_rst", 0, 0, c, 1);
    reset = 1'b1;
    #1;
    check("async_reset_drop", bus.pwm, 1'b0);
    cyc("rst_hold", 1, 0, 0, 0);
    cyc("rst_hold", 1, 0, 0, 0);
    for (int c = 0; c < P0; c++) cyc("post_rst", 0, 0, c, 1);
    for (int c = P0; c < P0 + 3; c++) cyc("post_rst", 0, 0, c, 0);

    // Reset during the low phase, restart with direction 1.
    cyc("rst_low", 1, 1, 0, 0);
    for (int c = 0; c < P1; c++) cyc("d1_restart", 0, 1, c, 1);
    cyc("d1_fall", 0, 1, P1, 0);

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
